fir_stream_mac: RTL and testbench
=================================

# fir_stream_mac

Parametrised streaming FIR filter: the next generation of the button-stepped FIR core. It takes signed samples over a valid/ready handshake and runs a time-multiplexed single-multiplier MAC over a TAPS-deep delay line. Coefficients are loaded at run time through a write port. It applies a rounded arithmetic right shift and saturates to the output width. It sits between a sample source (debounced key stepper or ADC front end) and the display/BCD path, all in the i_clk domain.

## Interface
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- TAPS, 8, filter length (≥2)
- OUT_W, 16, signed output width (≤ ACC_W)
- SHIFT, 0, right shift applied to accumulator before saturation (0..ACC_W-1)
- Derived: ACC_W = DATA_W+COEF_W+$clog2(TAPS); AW = $clog2(TAPS)

Ports:
- i_clk  in  1  system clock; everything is on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  AW  coefficient index (tap k)
- i_coef_data  in  COEF_W  signed coefficient value
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample
- i_data  in  DATA_W  signed input sample
- o_valid  out  1  output result valid
- i_ready  in  1  downstream accepts the result
- o_data  out  OUT_W  signed filtered result
- o_sat  out  1  the current o_data was clipped
- o_busy  out  1  MAC in progress

## Operation
- Delay line x[0..TAPS-1], with x[0] newest. Coefficient RAM c[0..TAPS-1]. The result is y = Σ x[k]·c[k].
- FSM states: IDLE, MAC, OUT.
  - IDLE: o_ready=1. On i_valid&o_ready: shift the delay line (x[k]←x[k-1], x[0]←i_data), clear acc, k←0, go to MAC.
  - MAC: one product per cycle, acc += x[k]·c[k] (full ACC_W signed). k=0..TAPS-1. After the k=TAPS-1 cycle, load output registers and go to OUT.
  - OUT: o_valid=1, with o_data/o_sat held stable. On i_ready, go to IDLE and drop o_valid.
- Output arithmetic:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - If r > 2^(OUT_W-1)-1: o_data = max, o_sat=1.
  - If r < -2^(OUT_W-1): o_data = min, o_sat=1.
  - Otherwise o_data = r, o_sat=0.
- Coefficient writes:
  - Accepted in IDLE and OUT. A write in OUT affects the next sample, not the held result.
  - Writes in MAC are dropped.
  - i_coef_addr ≥ TAPS is ignored.
  - A write and a sample accept in the same IDLE cycle: the write lands first. The new coefficient is used by that sample.
- o_busy = (state==MAC).
- Reset (any state, any cycle): state←IDLE; delay line, acc, k, all coefficients ←0; o_valid=0, o_data=0, o_sat=0; o_ready=1 on the cycle after reset. Reset wins over i_valid and i_coef_we in the same cycle. Reset mid-MAC discards the partial result.

## Timing
- Accept edge = cycle 0. MAC occupies cycles 1..TAPS. o_valid rises at cycle TAPS+1.
- With i_ready held high, o_valid lasts 1 cycle. o_ready returns at cycle TAPS+2.
- Minimum sample period is TAPS+2 cycles.
- o_ready=0 throughout MAC and OUT. i_valid is ignored there, and the source must hold its sample.
- Backpressure: o_data/o_sat are stable for as long as o_valid=1 and i_ready=0. There is no timeout.
- All outputs are registered. There is no combinational path from i_valid/i_ready to any output except o_ready (decoded from the state register only).

## Test plan
- Reset: assert i_rst for 2 cycles mid-MAC. Required response: next cycle o_valid=0, o_data=0, o_sat=0, o_busy=0, o_ready=1. A subsequent sample with all-zero coefficients gives o_data=0.
- Impulse response: TAPS=8, SHIFT=0, c[k]=k+1. Send 1 then seven 0s with i_ready=1. Required response: o_data = 1,2,3,4,5,6,7,8, then 0 for the next sample. Each o_valid comes exactly 9 cycles after its accept.
- Backpressure: hold i_ready=0 for 5 cycles during OUT. Required response: o_valid=1 and o_data constant for all 5, o_ready=0, and i_valid ignored. o_ready=1 one cycle after i_ready rises.
- Saturation: all c=127, eight inputs of 127, OUT_W=16. Required response: final o_data=32767, o_sat=1. All c=127 with eight inputs of -128: o_data=-32768, o_sat=1. A small input gives o_sat=0.
- Rounding: SHIFT=2, single tap c[0]=1, other taps 0, from a cleared line (reset first).
  - Input 6 gives o_data=2.
  - Input -6 gives o_data=-1.
  - Input 5 gives o_data=1.
- Coefficient timing:
  - A write of c[0]=9 during MAC is dropped; the next result uses the old c[0].
  - A write during OUT leaves the held o_data unchanged and applies to the next sample.
  - A write to addr 8 (TAPS=8) has no effect.

Source files
------------

// File: rtl/fir_stream_mac_if.sv
// Stream, result and coefficient-write signals of the FIR MAC, grouped for port use.
// The slave modport is the filter; the master modport is the sample source/sink.
interface fir_stream_mac_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     i_coef_we;
  logic [AW-1:0]            i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic                     i_valid;
  logic                     o_ready;
  logic signed [DATA_W-1:0] i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [OUT_W-1:0]  o_data;
  logic                     o_sat;
  logic                     o_busy;

  modport slave (
    input  i_coef_we, i_coef_addr, i_coef_data, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sat, o_busy
  );

  modport master (
    output i_coef_we, i_coef_addr, i_coef_data, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sat, o_busy
  );
endinterface

// File: rtl/fir_stream_mac.sv
// Streaming FIR: one product per cycle over a TAPS-deep delay line, followed by a
// round-half-up arithmetic shift and saturation to OUT_W. All outputs are registered.
module fir_stream_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  fir_stream_mac_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W:0] RND   = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAX_R = (ACC_W+1)'((longint'(1) <<< (OUT_W-1)) - longint'(1));
  localparam logic signed [ACC_W:0] MIN_R = ~MAX_R;
  localparam logic [AW-1:0]         LAST_K = AW'(TAPS-1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            k;
  logic                     ready_q;
  logic                     valid_q;
  logic                     busy_q;
  logic signed [OUT_W-1:0]  data_q;
  logic                     sat_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    r;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     sat_flag;
  logic                     addr_ok;

  assign addr_ok = int'(bus.i_coef_addr) < TAPS;

  // Final accumulation, rounding and clipping are computed from the last product
  // so the result registers load on the same edge as the k=TAPS-1 MAC step.
  always_comb begin
    prod     = x[k] * c[k];
    acc_sum  = acc + ACC_W'(prod);
    rnd_sum  = (ACC_W+1)'(acc_sum) + RND;
    r        = rnd_sum >>> SHIFT;
    sat_flag = 1'b0;
    sat_val  = OUT_W'(r);
    if (r > MAX_R) begin
      sat_val  = {1'b0, {(OUT_W-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (r < MIN_R) begin
      sat_val  = {1'b1, {(OUT_W-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      k       <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      if (bus.i_coef_we && state != ST_MAC && addr_ok)
        c[bus.i_coef_addr] <= bus.i_coef_data;

      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            for (int unsigned i = 1; i < TAPS; i++)
              x[i] <= x[i-1];
            x[0]    <= bus.i_data;
            acc     <= '0;
            k       <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_sum;
          k   <= k + AW'(1);
          if (k == LAST_K) begin
            data_q  <= sat_val;
            sat_q   <= sat_flag;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_data  = data_q;
  assign bus.o_sat   = sat_q;
endmodule

// File: tb/tb_fir_stream_mac.sv
// Bench for fir_stream_mac: two instances (SHIFT=0 and SHIFT=2) share one stimulus
// stream; results are checked against constant tables and a sum-of-products model.
module tb_fir_stream_mac;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 16;
  localparam int AW     = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_stream_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) b0 ();
  fir_stream_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) b1 ();

  assign b1.i_coef_we   = b0.i_coef_we;
  assign b1.i_coef_addr = b0.i_coef_addr;
  assign b1.i_coef_data = b0.i_coef_data;
  assign b1.i_valid     = b0.i_valid;
  assign b1.i_data      = b0.i_data;
  assign b1.i_ready     = b0.i_ready;

  fir_stream_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(0))
    dut0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
  fir_stream_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(2))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));

  int nerr = 0;
  int nchk = 0;
  int coef [TAPS];
  int hist [TAPS];
  int last0, last1;

  typedef struct {
    int x;
    int exp0;
    int sat0;
    int exp1;
    int sat1;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_acc();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += hist[i] * coef[i];
    return s;
  endfunction

  function automatic int quant(input int acc, input int sh, output int sat);
    int r;
    int lim;
    r   = (acc + (sh > 0 ? (1 << (sh - 1)) : 0)) >>> sh;
    lim = 1 << (OUT_W - 1);
    sat = 0;
    if (r > lim - 1) begin r = lim - 1; sat = 1; end
    else if (r < -lim) begin r = -lim; sat = 1; end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      coef[i] = 0;
      hist[i] = 0;
    end
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    b0.i_valid   = 1'b0;
    b0.i_coef_we = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drive_wr(input int a, input int d);
    b0.i_coef_we   = 1'b1;
    b0.i_coef_addr = AW'(a);
    b0.i_coef_data = COEF_W'(d);
  endtask

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    drive_wr(a, d);
    @(negedge clk);
    b0.i_coef_we = 1'b0;
    coef[a] = d;
  endtask

  // wr_when: 0 none, 1 same cycle as accept, 2 during MAC, 3 while the result is held
  task automatic send_sample(input int x, input int hold, input int wr_when,
                             input int wa, input int wd);
    int n;
    int e0, e1, s0, s1;
    @(negedge clk);
    chk("ready_idle", int'(b0.o_ready), 1);
    b0.i_valid = 1'b1;
    b0.i_data  = DATA_W'(x);
    b0.i_ready = (hold == 0);
    if (wr_when == 1) begin
      drive_wr(wa, wd);
      coef[wa] = wd;
    end
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    e0 = quant(model_acc(), 0, s0);
    e1 = quant(model_acc(), 2, s1);
    n = 0;
    while (!b0.o_valid && n <= 2 * TAPS + 4) begin
      @(negedge clk);
      n++;
      b0.i_valid   = 1'b0;
      b0.i_coef_we = 1'b0;
      if (wr_when == 2 && n == 3) drive_wr(wa, wd);
      if (n == 1) begin
        chk("busy_mac", int'(b0.o_busy), 1);
        chk("ready_mac", int'(b0.o_ready), 0);
      end
    end
    chk("latency", n, TAPS + 1);
    last0 = int'(b0.o_data);
    last1 = int'(b1.o_data);
    chk("model_data0", last0, e0);
    chk("model_sat0", int'(b0.o_sat), s0);
    chk("model_data1", last1, e1);
    chk("model_sat1", int'(b1.o_sat), s1);
    chk("busy_out", int'(b0.o_busy), 0);
    if (wr_when == 3) drive_wr(wa, wd);
    if (hold > 0) begin
      b0.i_valid = 1'b1;
      b0.i_data  = DATA_W'(x + 1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        b0.i_coef_we = 1'b0;
        chk("hold_valid", int'(b0.o_valid), 1);
        chk("hold_data0", int'(b0.o_data), last0);
        chk("hold_data1", int'(b1.o_data), last1);
        chk("hold_ready", int'(b0.o_ready), 0);
      end
      b0.i_ready = 1'b1;
    end
    @(negedge clk);
    b0.i_coef_we = 1'b0;
    b0.i_valid   = 1'b0;
    chk("ready_back", int'(b0.o_ready), 1);
    chk("valid_drop", int'(b0.o_valid), 0);
    chk("no_accept_in_out", int'(b0.o_busy), 0);
    if (wr_when == 3) coef[wa] = wd;
  endtask

  task automatic run_vecs(input string tag);
    foreach (tbl[i]) begin
      send_sample(tbl[i].x, 0, 0, 0, 0);
      chk($sformatf("%s[%0d].data0", tag, i), last0, tbl[i].exp0);
      chk($sformatf("%s[%0d].sat0", tag, i), int'(b0.o_sat), tbl[i].sat0);
      chk($sformatf("%s[%0d].data1", tag, i), last1, tbl[i].exp1);
      chk($sformatf("%s[%0d].sat1", tag, i), int'(b1.o_sat), tbl[i].sat1);
    end
    tbl.delete();
  endtask

  initial begin
    int hold, wr_when, wa, wd;
    rst = 1'b1;
    b0.i_valid = 1'b0;
    b0.i_data = '0;
    b0.i_ready = 1'b1;
    b0.i_coef_we = 1'b0;
    b0.i_coef_addr = '0;
    b0.i_coef_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", int'(b0.o_valid), 0);
    chk("rst_ready", int'(b0.o_ready), 1);
    chk("rst_busy", int'(b0.o_busy), 0);
    chk("rst_data", int'(b0.o_data), 0);
    chk("rst_sat", int'(b0.o_sat), 0);

    // Reset in the middle of a MAC, then a sample through cleared coefficients
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    @(negedge clk);
    b0.i_valid = 1'b1;
    b0.i_data  = DATA_W'(7);
    @(negedge clk);
    b0.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", int'(b0.o_busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("midrst_valid", int'(b0.o_valid), 0);
    chk("midrst_data", int'(b0.o_data), 0);
    chk("midrst_sat", int'(b0.o_sat), 0);
    chk("midrst_busy", int'(b0.o_busy), 0);
    chk("midrst_ready", int'(b0.o_ready), 1);
    tbl.push_back('{5, 0, 0, 0, 0});
    run_vecs("zero_coef");

    // Impulse response with c[k]=k+1
    do_reset(2);
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    tbl.push_back('{1, 1, 0, 0, 0});
    tbl.push_back('{0, 2, 0, 1, 0});
    tbl.push_back('{0, 3, 0, 1, 0});
    tbl.push_back('{0, 4, 0, 1, 0});
    tbl.push_back('{0, 5, 0, 1, 0});
    tbl.push_back('{0, 6, 0, 2, 0});
    tbl.push_back('{0, 7, 0, 2, 0});
    tbl.push_back('{0, 8, 0, 2, 0});
    tbl.push_back('{0, 0, 0, 0, 0});
    run_vecs("impulse");

    // Backpressure with a held-result coefficient write, then dropped MAC write
    send_sample(3, 5, 3, 1, -4);
    chk("bp_data", last0, 3);
    send_sample(2, 0, 2, 0, 9);
    chk("out_write_applied", last0, -10);
    send_sample(1, 0, 0, 0, 0);
    chk("mac_write_dropped", last0, 2);
    send_sample(4, 0, 1, 2, 5);
    chk("accept_write_first", last0, 22);

    // Saturation in both directions
    do_reset(2);
    for (int i = 0; i < TAPS; i++) wcoef(i, 127);
    tbl.push_back('{127, 16129, 0, 4032, 0});
    tbl.push_back('{127, 32258, 0, 8065, 0});
    tbl.push_back('{127, 32767, 1, 12097, 0});
    tbl.push_back('{127, 32767, 1, 16129, 0});
    tbl.push_back('{127, 32767, 1, 20161, 0});
    tbl.push_back('{127, 32767, 1, 24194, 0});
    tbl.push_back('{127, 32767, 1, 28226, 0});
    tbl.push_back('{127, 32767, 1, 32258, 0});
    tbl.push_back('{-128, 32767, 1, 24162, 0});
    tbl.push_back('{-128, 32767, 1, 16066, 0});
    tbl.push_back('{-128, 31877, 0, 7969, 0});
    tbl.push_back('{-128, -508, 0, -127, 0});
    tbl.push_back('{-128, -32768, 1, -8223, 0});
    tbl.push_back('{-128, -32768, 1, -16319, 0});
    tbl.push_back('{-128, -32768, 1, -24416, 0});
    tbl.push_back('{-128, -32768, 1, -32512, 0});
    run_vecs("sat");

    // Rounding through a single unit tap
    do_reset(2);
    wcoef(0, 1);
    tbl.push_back('{6, 6, 0, 2, 0});
    tbl.push_back('{-6, -6, 0, -1, 0});
    tbl.push_back('{5, 5, 0, 1, 0});
    run_vecs("round");

    // Randomized samples, holds and coefficient writes against the model
    do_reset(2);
    for (int i = 0; i < TAPS; i++) wcoef(i, int'($urandom_range(255)) - 128);
    for (int t = 0; t < 30; t++) begin
      hold    = int'($urandom_range(3));
      wr_when = int'($urandom_range(3));
      wa      = int'($urandom_range(TAPS - 1));
      wd      = int'($urandom_range(255)) - 128;
      send_sample(int'($urandom_range(255)) - 128, hold, wr_when, wa, wd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
